spectrum_frame_buffer: RTL and testbench

//  Consumes the 8-bit log-magnitude stream (log_out/log_valid/log_last) from log_scale and

---
 rtl/spectrum_frame_buffer_pkg.sv | 19 +
 rtl/spectrum_frame_buffer_bin_ram.sv | 29 ++
 rtl/spectrum_frame_buffer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_spectrum_frame_buffer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_frame_buffer_pkg.sv
// Shared definitions for the spectrum frame buffer: default sizes, the
// address-width helper and the clear/run state type.
package spectrum_pkg;

    localparam int DEF_LOG_W      = 8;
    localparam int DEF_NUM_BINS   = 512;
    localparam int DEF_DECAY_STEP = 2;

    // Address width for a RAM of n entries; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/spectrum_frame_buffer_bin_ram.sv
// bin_ram: simple dual-port bin memory with one write port and one
// registered read port. The array itself is not reset; the frame buffer
// zeroes it by sweeping the write port after reset.
module bin_ram
    import spectrum_pkg::*;
#(
    parameter int DEPTH = DEF_NUM_BINS,
    parameter int WIDTH = DEF_LOG_W,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write plus a read that is registered every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer: assembles one frame of log-magnitude bins per
// log_last into a ping-pong RAM pair; the display side reads the last
// completed frame while the next one is being written.
// Optional feature macro: PEAK_HOLD_EN (per-bin decaying peak hold, adds
// one pipeline stage to the write path and a third RAM).
module spectrum_frame_buffer
    import spectrum_pkg::*;
#(
    parameter int NUM_BINS   = DEF_NUM_BINS,
    parameter int LOG_W      = DEF_LOG_W,
    parameter int DECAY_STEP = DEF_DECAY_STEP,
    localparam int ADDR_W    = addr_w(NUM_BINS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LOG_W-1:0]  log_in,
    input  logic              log_valid,
    input  logic              log_last,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [LOG_W-1:0]  rd_data,
    output logic              frame_ready,
    output logic              busy,
    output logic              short_frame,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

    // Static sanity checks on the configuration.
    if ((NUM_BINS & (NUM_BINS - 1)) != 0) begin : g_bad_num_bins
        $error("NUM_BINS must be a power of two");
    end
    if (DECAY_STEP < 0 || DECAY_STEP >= (1 << LOG_W)) begin : g_bad_decay
        $error("DECAY_STEP must fit in LOG_W bits");
    end

    fsm_state_t        state;
    logic [ADDR_W-1:0] clr_addr;
    logic              clearing;

    // Intake bookkeeping: next bin to fill and the bank new samples go to.
    logic [ADDR_W-1:0] wr_bin;
    logic              bin_full;
    logic              wr_bank;
    logic              disp_bank;
    logic              accept;

    // Stage 1: registered copy of the accepted sample.
    logic              s1_valid;
    logic              s1_write;
    logic [ADDR_W-1:0] s1_addr;
    logic [LOG_W-1:0]  s1_data;
    logic              s1_bank;
    logic              s1_last;
    logic              s1_short;

    // Commit point of the write pipeline (stage 1 or stage 2).
    logic              c_valid;
    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [LOG_W-1:0]  c_data;
    logic              c_bank;
    logic              c_last;
    logic              c_short;

    // Shared RAM write port signals; the clear sweep overrides commits.
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [LOG_W-1:0]  ram_wr_data;
    logic [1:0]        bank_we;
    logic [LOG_W-1:0]  bank0_rd;
    logic [LOG_W-1:0]  bank1_rd;

    // Read-side select and mask, captured in the same cycle as the RAM read.
    logic              rd_sel_q;
    logic              rd_mask_q;

    assign clearing = (state == CLEAR);
    assign accept   = (state == RUN) && log_valid;

    // Post-reset clear sweep: one address per cycle, then hand over to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_BIN) begin
                        state    <= RUN;
                        busy     <= 1'b0;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Accept samples, assign bins, saturate at the last bin and flag
    // overflow; the next frame starts immediately after an accepted log_last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bin   <= '0;
            bin_full <= 1'b0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
            s1_valid <= 1'b0;
            s1_write <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s1_bank  <= 1'b0;
            s1_last  <= 1'b0;
            s1_short <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (c_valid && c_last) begin
                overflow <= 1'b0;
            end
            if (accept) begin
                s1_write <= !bin_full;
                s1_addr  <= wr_bin;
                s1_data  <= log_in;
                s1_bank  <= wr_bank;
                s1_last  <= log_last;
                s1_short <= (wr_bin < LAST_BIN);
                if (bin_full) begin
                    overflow <= 1'b1;
                end
                if (log_last) begin
                    wr_bin   <= '0;
                    bin_full <= 1'b0;
                    wr_bank  <= ~wr_bank;
                end else if (!bin_full) begin
                    if (wr_bin == LAST_BIN) begin
                        bin_full <= 1'b1;
                    end else begin
                        wr_bin <= wr_bin + 1'b1;
                    end
                end
            end
        end
    end

`ifdef PEAK_HOLD_EN
    localparam logic [LOG_W-1:0] DECAY = LOG_W'(DECAY_STEP);

    logic [LOG_W-1:0]  peak_rd;
    logic [LOG_W-1:0]  decayed;
    logic [LOG_W-1:0]  peak_new;

    logic              s2_valid;
    logic              s2_write;
    logic [ADDR_W-1:0] s2_addr;
    logic [LOG_W-1:0]  s2_data;
    logic              s2_bank;
    logic              s2_last;
    logic              s2_short;

    // The peak RAM is read at the bin being accepted so the old peak lines
    // up with the stage 1 sample one cycle later.
    bin_ram #(.DEPTH(NUM_BINS), .WIDTH(LOG_W)) u_peak_ram (
        .clk     (clk),
        .we      (clearing || c_write),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (wr_bin),
        .rd_data (peak_rd)
    );

    // Decay the old peak with a floor at zero and keep the larger value.
    always_comb begin
        decayed  = (peak_rd >= DECAY) ? (peak_rd - DECAY) : '0;
        peak_new = (s1_data > decayed) ? s1_data : decayed;
    end

    // Stage 2 holds the peak-held value until it commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_write <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            s2_bank  <= 1'b0;
            s2_last  <= 1'b0;
            s2_short <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_write <= s1_valid && s1_write;
            s2_addr  <= s1_addr;
            s2_data  <= peak_new;
            s2_bank  <= s1_bank;
            s2_last  <= s1_last;
            s2_short <= s1_short;
        end
    end

    assign c_valid = s2_valid;
    assign c_write = s2_write;
    assign c_addr  = s2_addr;
    assign c_data  = s2_data;
    assign c_bank  = s2_bank;
    assign c_last  = s2_last;
    assign c_short = s2_short;
`else
    assign c_valid = s1_valid;
    assign c_write = s1_valid && s1_write;
    assign c_addr  = s1_addr;
    assign c_data  = s1_data;
    assign c_bank  = s1_bank;
    assign c_last  = s1_last;
    assign c_short = s1_short;
`endif

    assign ram_wr_addr = clearing ? clr_addr : c_addr;
    assign ram_wr_data = clearing ? '0 : c_data;
    assign bank_we[0]  = clearing || (c_write && !c_bank);
    assign bank_we[1]  = clearing || (c_write && c_bank);

    bin_ram #(.DEPTH(NUM_BINS), .WIDTH(LOG_W)) u_bank0 (
        .clk     (clk),
        .we      (bank_we[0]),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (rd_addr),
        .rd_data (bank0_rd)
    );

    bin_ram #(.DEPTH(NUM_BINS), .WIDTH(LOG_W)) u_bank1 (
        .clk     (clk),
        .we      (bank_we[1]),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (rd_addr),
        .rd_data (bank1_rd)
    );

    // Swap banks when the last sample of a frame commits and announce it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bank   <= 1'b1;
            frame_ready <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            frame_ready <= c_valid && c_last;
            short_frame <= c_valid && c_last && c_short;
            if (c_valid && c_last) begin
                disp_bank <= c_bank;
            end
        end
    end

    // Remember which bank was displayed, and whether we were clearing,
    // in the cycle each read was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel_q  <= 1'b1;
            rd_mask_q <= 1'b1;
        end else begin
            rd_sel_q  <= disp_bank;
            rd_mask_q <= busy;
        end
    end

    assign rd_data = rd_mask_q ? '0 : (rd_sel_q ? bank1_rd : bank0_rd);

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// Directed testbench for spectrum_frame_buffer (default 512 bins, 8-bit).
// Honours PEAK_HOLD_EN when the design is built with it.
module tb_spectrum_frame_buffer;

    localparam int NB = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] log_in = 8'd0;
    logic       log_valid = 1'b0;
    logic       log_last = 1'b0;
    logic [8:0] rd_addr = 9'd0;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic       busy;
    logic       short_frame;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int fr_count = 0;
    int sf_count = 0;

    logic [7:0] bank_m [2][NB];
    logic [7:0] peak_m [NB];
    logic       wb_m;
    logic       disp_m;

    spectrum_frame_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .log_in      (log_in),
        .log_valid   (log_valid),
        .log_last    (log_last),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .busy        (busy),
        .short_frame (short_frame),
        .overflow    (overflow)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Count pulses; each pulse lasts one full cycle so it is seen at one posedge.
    always @(posedge clk) begin
        if (frame_ready === 1'b1) fr_count++;
        if (short_frame === 1'b1) sf_count++;
    end

    // Reference: value the design should store for a sample in a given bin.
    function automatic logic [7:0] model_store(input int bin, input logic [7:0] v);
`ifdef PEAK_HOLD_EN
        logic [7:0] d;
        logic [7:0] s;
        d = (peak_m[bin] >= 8'd2) ? (peak_m[bin] - 8'd2) : 8'd0;
        s = (v > d) ? v : d;
        peak_m[bin] = s;
        return s;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            bank_m[0][i] = 8'd0;
            bank_m[1][i] = 8'd0;
            peak_m[i]    = 8'd0;
        end
        wb_m   = 1'b0;
        disp_m = 1'b1;
    endtask

    task automatic send(input logic [7:0] v, input logic last);
        log_in    = v;
        log_valid = 1'b1;
        log_last  = last;
        @(negedge clk);
        log_valid = 1'b0;
        log_last  = 1'b0;
    endtask

    task automatic read_bin(input int a, output logic [7:0] v);
        rd_addr = a[8:0];
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic wait_frame(output logic got, output logic sf);
        got = 1'b0;
        sf  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (frame_ready === 1'b1) begin
                got = 1'b1;
                sf  = short_frame;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc;
        int fr0;
        logic [7:0] v;
        $display("[TB] test_reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || frame_ready !== 1'b0 || short_frame !== 1'b0 ||
            overflow !== 1'b0 || rd_data !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_values: busy=%b fr=%b sf=%b ovf=%b rd=%h, want 1 0 0 0 00",
                     busy, frame_ready, short_frame, overflow, rd_data);
        end
        rst = 1'b0;
        fr0 = fr_count;
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 512) begin
            failures++;
            $display("[TB] FAIL busy_length: got %0d cycles, want 512", cyc);
        end
        model_reset();
        for (int a = 0; a < NB; a++) begin
            read_bin(a, v);
            checks++;
            if (v !== 8'd0) begin
                failures++;
                $display("[TB] FAIL reset_read bin %0d: got %h, want 00", a, v);
            end
        end
        checks++;
        if (fr_count != fr0) begin
            failures++;
            $display("[TB] FAIL reset_no_frame_ready: got %0d pulses, want 0", fr_count - fr0);
        end
    endtask

    task automatic test_full_frame();
        int fr0;
        logic got, sf;
        logic [7:0] v;
        $display("[TB] test_full_frame");
        fr0 = fr_count;
        for (int b = 0; b < NB; b++) begin
            bank_m[wb_m][b] = model_store(b, b[7:0]);
            send(b[7:0], b == NB - 1);
        end
        wait_frame(got, sf);
        disp_m = wb_m;
        wb_m   = ~wb_m;
        checks++;
        if (got !== 1'b1 || sf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_frame_ready: got fr=%b sf=%b, want 1 0", got, sf);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fr_count != fr0 + 1) begin
            failures++;
            $display("[TB] FAIL full_frame_pulses: got %0d, want 1", fr_count - fr0);
        end
        for (int a = 0; a < NB; a++) begin
            read_bin(a, v);
            checks++;
            if (v !== bank_m[disp_m][a]) begin
                failures++;
                $display("[TB] FAIL full_read bin %0d: got %h, want %h", a, v, bank_m[disp_m][a]);
            end
        end
    endtask

    task automatic test_short_frame();
        int fr0, sf0;
        logic got, sf;
        logic [7:0] v;
        $display("[TB] test_short_frame");
        fr0 = fr_count;
        sf0 = sf_count;
        for (int b = 0; b < 100; b++) begin
            bank_m[wb_m][b] = model_store(b, 8'h55);
            send(8'h55, b == 99);
        end
        wait_frame(got, sf);
        disp_m = wb_m;
        wb_m   = ~wb_m;
        checks++;
        if (got !== 1'b1 || sf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL short_frame_flags: got fr=%b sf=%b, want 1 1", got, sf);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fr_count != fr0 + 1 || sf_count != sf0 + 1) begin
            failures++;
            $display("[TB] FAIL short_frame_pulses: got fr %0d sf %0d, want 1 1",
                     fr_count - fr0, sf_count - sf0);
        end
        for (int a = 0; a < NB; a++) begin
            read_bin(a, v);
            checks++;
            if (v !== bank_m[disp_m][a]) begin
                failures++;
                $display("[TB] FAIL short_read bin %0d: got %h, want %h", a, v, bank_m[disp_m][a]);
            end
        end
    endtask

    task automatic test_overflow();
        logic got, sf;
        logic [7:0] v;
        logic [7:0] sv;
        $display("[TB] test_overflow");
        for (int s = 0; s < 520; s++) begin
            sv = 8'((s * 3) + 7);
            if (s < NB) bank_m[wb_m][s] = model_store(s, sv);
            send(sv, s == 519);
            if (s == 511) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL overflow_early: got %b after 512 samples, want 0", overflow);
                end
            end
            if (s == 512 || s == 519) begin
                checks++;
                if (overflow !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL overflow_set sample %0d: got %b, want 1", s + 1, overflow);
                end
            end
        end
        wait_frame(got, sf);
        disp_m = wb_m;
        wb_m   = ~wb_m;
        checks++;
        if (got !== 1'b1 || sf !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow_swap: got fr=%b sf=%b ovf=%b, want 1 0 0", got, sf, overflow);
        end
        for (int a = 0; a < NB; a++) begin
            read_bin(a, v);
            checks++;
            if (v !== bank_m[disp_m][a]) begin
                failures++;
                $display("[TB] FAIL overflow_read bin %0d: got %h, want %h", a, v, bank_m[disp_m][a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fr0, sf0;
        logic [7:0] v;
        $display("[TB] test_back_to_back");
        fr0 = fr_count;
        sf0 = sf_count;
        for (int b = 0; b < 4; b++) begin
            bank_m[wb_m][b] = model_store(b, 8'h11 + 8'(b));
            send(8'h11 + 8'(b), b == 3);
        end
        wb_m = ~wb_m;
        for (int b = 0; b < 4; b++) begin
            bank_m[wb_m][b] = model_store(b, 8'h21 + 8'(b));
            send(8'h21 + 8'(b), b == 3);
        end
        disp_m = wb_m;
        wb_m   = ~wb_m;
        repeat (6) @(negedge clk);
        checks++;
        if (fr_count != fr0 + 2 || sf_count != sf0 + 2) begin
            failures++;
            $display("[TB] FAIL b2b_pulses: got fr %0d sf %0d, want 2 2", fr_count - fr0, sf_count - sf0);
        end
        for (int a = 0; a < 8; a++) begin
            read_bin(a, v);
            checks++;
            if (v !== bank_m[disp_m][a]) begin
                failures++;
                $display("[TB] FAIL b2b_read bin %0d: got %h, want %h", a, v, bank_m[disp_m][a]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int fr0, cyc;
        logic got, sf;
        logic [7:0] v;
        $display("[TB] test_reset_mid_frame");
        for (int b = 0; b < NB; b++) begin
            bank_m[wb_m][b] = model_store(b, b[7:0] ^ 8'h3C);
            send(b[7:0] ^ 8'h3C, b == NB - 1);
        end
        wait_frame(got, sf);
        disp_m = wb_m;
        wb_m   = ~wb_m;
        for (int a = 0; a < 4; a++) begin
            read_bin(a * 100, v);
            checks++;
            if (v !== bank_m[disp_m][a * 100]) begin
                failures++;
                $display("[TB] FAIL frame1_read bin %0d: got %h, want %h", a * 100, v, bank_m[disp_m][a * 100]);
            end
        end
        fr0 = fr_count;
        for (int b = 0; b < 200; b++) send(8'hF0, 1'b0);
        log_in    = 8'hF0;
        log_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || frame_ready !== 1'b0 || short_frame !== 1'b0 ||
            overflow !== 1'b0 || rd_data !== 8'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: busy=%b fr=%b sf=%b ovf=%b rd=%h, want 1 0 0 0 00",
                     busy, frame_ready, short_frame, overflow, rd_data);
        end
        @(negedge clk);
        log_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 512) begin
            failures++;
            $display("[TB] FAIL reclear_length: got %0d cycles, want 512", cyc);
        end
        model_reset();
        for (int a = 0; a < NB; a++) begin
            read_bin(a, v);
            checks++;
            if (v !== 8'd0) begin
                failures++;
                $display("[TB] FAIL reclear_read bin %0d: got %h, want 00", a, v);
            end
        end
        checks++;
        if (fr_count != fr0) begin
            failures++;
            $display("[TB] FAIL reclear_no_frame_ready: got %0d pulses, want 0", fr_count - fr0);
        end
    endtask

`ifdef PEAK_HOLD_EN
    task automatic test_peak_hold();
        logic got, sf;
        logic [7:0] v;
        logic [7:0] vals [3];
        logic [7:0] want [3];
        $display("[TB] test_peak_hold");
        vals[0] = 8'd200; vals[1] = 8'd10;  vals[2] = 8'd250;
        want[0] = 8'd200; want[1] = 8'd198; want[2] = 8'd250;
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < NB; b++) send(vals[f], b == NB - 1);
            wait_frame(got, sf);
            checks++;
            if (got !== 1'b1) begin
                failures++;
                $display("[TB] FAIL peak_frame_ready frame %0d: got %b, want 1", f, got);
            end
            for (int a = 0; a < NB; a += 37) begin
                read_bin(a, v);
                checks++;
                if (v !== want[f]) begin
                    failures++;
                    $display("[TB] FAIL peak_read frame %0d bin %0d: got %0d, want %0d", f, a, v, want[f]);
                end
            end
        end
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        model_reset();
        test_reset();
        test_full_frame();
        test_short_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef PEAK_HOLD_EN
        test_peak_hold();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
